// File: rtl/serial_pkg.sv
// Shared constants for the serial frame transformer: FSM state codes, mode codes
// and small helpers that decode the mode field.
package serial_pkg;

  localparam logic [1:0] READ = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [1:0] MODE_FWD    = 2'd0;
  localparam logic [1:0] MODE_REV    = 2'd1;
  localparam logic [1:0] MODE_REV_CS = 2'd2;
  localparam logic [1:0] MODE_FWD_CS = 2'd3;

  function automatic logic mode_is_rev(input logic [1:0] m);
    return (m == MODE_REV) || (m == MODE_REV_CS);
  endfunction

  function automatic logic mode_has_cs(input logic [1:0] m);
    return (m == MODE_REV_CS) || (m == MODE_FWD_CS);
  endfunction

endpackage

// File: rtl/frame_transformer_if.sv
// Bundle of the rx/tx handshake and status signals around the frame transformer.
// The slave modport is the transformer itself; master is its environment.
interface frame_transformer_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        mode;
  logic              rxReady;
  logic [DATA_W-1:0] rxData;
  logic              txBusy;
  logic              txStart;
  logic [DATA_W-1:0] txData;
  logic              busy;
  logic              frameDone;
  logic              frameDrop;
  logic              rxOverrun;

  modport master (
    output mode, rxReady, rxData, txBusy,
    input  txStart, txData, busy, frameDone, frameDrop, rxOverrun
  );

  modport slave (
    input  mode, rxReady, rxData, txBusy,
    output txStart, txData, busy, frameDone, frameDrop, rxOverrun
  );
endinterface

// File: rtl/frame_transformer_idle_timer.sv
// Idle counter for partial frames: counts enabled cycles, restarts on clear,
// and flags the cycle on which TIMEOUT_CYC idle cycles have elapsed.
module idle_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_end;

  assign at_end  = (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign expired = enable && !clear && at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expired) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/frame_transformer.sv
// Collects FRAME_LEN received words, then replays them forward or reversed,
// optionally followed by a mod-2^DATA_W checksum word.
module frame_transformer
  import serial_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int FRAME_LEN   = 3,
  parameter int TIMEOUT_CYC = 0
) (
  input logic               clk,
  input logic               resetN,
  frame_transformer_if.slave bus
);
  localparam int IW = $clog2(FRAME_LEN + 1);
  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     count_q, count_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [1:0]        mode_q, mode_d;
  logic              txStart_q, txStart_d;
  logic [DATA_W-1:0] txData_q, txData_d;
  logic              busy_q, busy_d;
  logic              frameDone_q, frameDone_d;
  logic              frameDrop_q, frameDrop_d;
  logic              rxOverrun_q, rxOverrun_d;

  logic [DATA_W-1:0] buf_q [FRAME_LEN];
  logic              wr_en;
  logic              expired;
  logic [IW-1:0]     rd_idx;
  logic [IW-1:0]     last;
  logic [DATA_W-1:0] word;

  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      logic partial;
      assign partial = (state_q == READ) && (count_q != '0) && (count_q < IW'(FRAME_LEN));
      idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
        .clk    (clk),
        .resetN (resetN),
        .clear  (bus.rxReady || !partial),
        .enable (partial),
        .expired(expired)
      );
    end else begin : g_no_timer
      assign expired = 1'b0;
    end
  endgenerate

  // Index FRAME_LEN is the checksum slot, past the end of the buffer.
  always_comb begin
    rd_idx = mode_is_rev(mode_q) ? (IW'(FRAME_LEN - 1) - idx_q) : idx_q;
    last   = mode_has_cs(mode_q) ? IW'(FRAME_LEN) : IW'(FRAME_LEN - 1);
    word   = (idx_q == IW'(FRAME_LEN)) ? sum_q : buf_q[rd_idx[AW-1:0]];
  end

  assign wr_en = (state_q == READ) && bus.rxReady;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[count_q[AW-1:0]] <= bus.rxData;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    mode_d      = mode_q;
    txStart_d   = 1'b0;
    txData_d    = txData_q;
    busy_d      = busy_q;
    frameDone_d = 1'b0;
    frameDrop_d = 1'b0;
    rxOverrun_d = rxOverrun_q || (bus.rxReady && busy_q);

    case (state_q)
      READ: begin
        if (bus.rxReady) begin
          sum_d   = sum_q + bus.rxData;
          count_d = count_q + IW'(1);
          if (count_q == '0) begin
            mode_d = bus.mode;
          end
          if (count_q == IW'(FRAME_LEN - 1)) begin
            state_d = SEND;
            busy_d  = 1'b1;
            idx_d   = '0;
          end
        end else if (expired) begin
          count_d     = '0;
          sum_d       = '0;
          frameDrop_d = 1'b1;
        end
      end
      SEND: begin
        if (!bus.txBusy) begin
          txStart_d = 1'b1;
          txData_d  = word;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (idx_q < last) begin
          idx_d   = idx_q + IW'(1);
          state_d = SEND;
        end else begin
          frameDone_d = 1'b1;
          state_d     = READ;
          count_d     = '0;
          sum_d       = '0;
          busy_d      = 1'b0;
        end
      end
      default: state_d = READ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= READ;
      count_q     <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      mode_q      <= MODE_FWD;
      txStart_q   <= 1'b0;
      txData_q    <= '0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
      frameDrop_q <= 1'b0;
      rxOverrun_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      mode_q      <= mode_d;
      txStart_q   <= txStart_d;
      txData_q    <= txData_d;
      busy_q      <= busy_d;
      frameDone_q <= frameDone_d;
      frameDrop_q <= frameDrop_d;
      rxOverrun_q <= rxOverrun_d;
    end
  end

  assign bus.txStart   = txStart_q;
  assign bus.txData    = txData_q;
  assign bus.busy      = busy_q;
  assign bus.frameDone = frameDone_q;
  assign bus.frameDrop = frameDrop_q;
  assign bus.rxOverrun = rxOverrun_q;
endmodule

// File: tb/tb_frame_transformer.sv
// Scoreboard bench for frame_transformer: stimulus pushes expected tx words,
// a monitor pops and compares on every txStart.
module tb_frame_transformer;
  localparam int DATA_W      = 8;
  localparam int FRAME_LEN   = 3;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  frame_transformer_if #(.DATA_W(DATA_W)) ifc ();

  frame_transformer #(
    .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (ifc)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int tx_cnt = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  logic force_busy = 1'b0;
  logic prev_start = 1'b0;
  logic [7:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (resetN) begin
        if (ifc.txStart) begin
          tx_cnt++;
          check("tx_spacing", prev_start, 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got %0h expected no transmit", ifc.txData);
          end else begin
            mon_e = exp_q.pop_front();
            check("tx_data", ifc.txData, mon_e);
          end
        end
        if (ifc.frameDone) begin
          done_cnt++;
          check("done_follows_start", prev_start, 1);
        end
        if (ifc.frameDrop) drop_cnt++;
      end
      prev_start = ifc.txStart;
    end
  end

  // Transmitter model: busy for 10 cycles after each txStart
  initial begin
    int cnt;
    cnt = 0;
    ifc.txBusy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ifc.txStart) cnt = 10;
      ifc.txBusy = force_busy || (cnt > 0);
      if (cnt > 0) cnt--;
    end
  end

  task automatic send_word(input logic [7:0] d);
    ifc.rxData  = d;
    ifc.rxReady = 1'b1;
    @(negedge clk);
    ifc.rxReady = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c);
    ifc.mode = m;
    send_word(a);
    ifc.mode = m ^ 2'b01;
    send_word(b);
    send_word(c);
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((ifc.busy || exp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completes"}, (n < 400), 1);
  endtask

  initial begin
    int d0, t0, r0, n;
    ifc.mode    = 2'd0;
    ifc.rxReady = 1'b0;
    ifc.rxData  = '0;
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txStart", ifc.txStart, 0);
    check("rst_txData", ifc.txData, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_frameDone", ifc.frameDone, 0);
    check("rst_frameDrop", ifc.frameDrop, 0);
    check("rst_rxOverrun", ifc.rxOverrun, 0);
    resetN = 1'b1;
    @(negedge clk);

    // 1: reverse
    d0 = done_cnt;
    push3(8'h33, 8'h22, 8'h11);
    send_frame(2'd1, 8'h11, 8'h22, 8'h33);
    check("t1_busy_after_capture", ifc.busy, 1);
    wait_idle("t1");
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_busy_low", ifc.busy, 0);

    // 2: reverse + checksum, then forward
    d0 = done_cnt;
    push3(8'h33, 8'h22, 8'h11);
    exp_q.push_back(8'h66);
    send_frame(2'd2, 8'h11, 8'h22, 8'h33);
    wait_idle("t2a");
    push3(8'h11, 8'h22, 8'h33);
    send_frame(2'd0, 8'h11, 8'h22, 8'h33);
    wait_idle("t2b");
    check("t2_done_pulses", done_cnt - d0, 2);

    // 3: forward + checksum with wrap
    push3(8'hFF, 8'h02, 8'h01);
    exp_q.push_back(8'h02);
    send_frame(2'd3, 8'hFF, 8'h02, 8'h01);
    wait_idle("t3");

    // 4: timeout discards partial frame
    r0 = drop_cnt;
    t0 = tx_cnt;
    ifc.mode = 2'd0;
    send_word(8'hAA);
    repeat (15) @(negedge clk);
    check("t4_no_early_drop", drop_cnt - r0, 0);
    repeat (2) @(negedge clk);
    check("t4_drop_pulse", drop_cnt - r0, 1);
    check("t4_no_tx", tx_cnt - t0, 0);
    push3(8'h01, 8'h02, 8'h03);
    send_frame(2'd0, 8'h01, 8'h02, 8'h03);
    wait_idle("t4a");
    // words landing exactly on the expiry edge are kept
    r0 = drop_cnt;
    push3(8'h04, 8'h05, 8'h06);
    ifc.mode = 2'd0;
    send_word(8'h04);
    repeat (15) @(negedge clk);
    send_word(8'h05);
    repeat (15) @(negedge clk);
    send_word(8'h06);
    wait_idle("t4b");
    check("t4_no_drop_on_coincide", drop_cnt - r0, 0);

    // 5: overrun while busy
    check("t5_overrun_clear", ifc.rxOverrun, 0);
    push3(8'h12, 8'h34, 8'h56);
    send_frame(2'd0, 8'h12, 8'h34, 8'h56);
    send_word(8'h55);
    check("t5_overrun_set", ifc.rxOverrun, 1);
    wait_idle("t5");
    check("t5_overrun_sticky", ifc.rxOverrun, 1);

    // 6: reset after second txStart
    t0 = tx_cnt;
    d0 = done_cnt;
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    send_frame(2'd0, 8'hA1, 8'hA2, 8'hA3);
    n = 0;
    while (tx_cnt < t0 + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_two_starts_seen", (n < 200), 1);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    check("t6_txStart_low", ifc.txStart, 0);
    check("t6_busy_low", ifc.busy, 0);
    check("t6_overrun_reset", ifc.rxOverrun, 0);
    repeat (40) @(negedge clk);
    check("t6_no_more_tx", tx_cnt - t0, 2);
    check("t6_no_done", done_cnt - d0, 0);
    push3(8'h03, 8'h02, 8'h01);
    send_frame(2'd1, 8'h01, 8'h02, 8'h03);
    wait_idle("t6");

    // 7: transmitter held busy
    force_busy = 1'b1;
    @(negedge clk);
    t0 = tx_cnt;
    push3(8'hB1, 8'hB2, 8'hB3);
    send_frame(2'd0, 8'hB1, 8'hB2, 8'hB3);
    repeat (100) @(negedge clk);
    check("t7_no_start", tx_cnt - t0, 0);
    check("t7_txData_held", ifc.txData, 8'h01);
    force_busy = 1'b0;
    @(negedge clk);
    check("t7_busy_fell", ifc.txBusy, 0);
    check("t7_not_yet", ifc.txStart, 0);
    @(negedge clk);
    check("t7_first_start", ifc.txStart, 1);
    check("t7_first_data", ifc.txData, 8'hB1);
    wait_idle("t7");

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end
endmodule
